// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types and helpers for the SPI register bank.
//   state_t  : frame-decoder states
//   RD_BIT   : read/write flag position in the command word (default 8-bit word)
//   is_oor() : decides whether a command word addresses a register that exists
package spi_reg_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        CMD       = 2'd2,
        DATA      = 2'd3
    } state_t;

    localparam int NBIT_DEFAULT = 8;
    localparam int RD_BIT       = NBIT_DEFAULT - 1;

    // A command is out of range when any bit between the address field and
    // the RD flag is set, or when the address field itself is >= nregs.
    // The command is passed zero-extended to 32 bits so the same helper
    // serves any word width.
    function automatic logic is_oor(input logic [31:0] cmd, input int nbit, input int nregs);
        int          aw;
        logic [31:0] addr_v;
        logic        oor;
        aw  = (nregs > 1) ? $clog2(nregs) : 1;
        oor = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i >= aw && i < nbit - 1 && cmd[i]) begin
                oor = 1'b1;
            end
        end
        addr_v = cmd & ((32'd1 << aw) - 32'd1);
        if (addr_v >= 32'(nregs)) begin
            oor = 1'b1;
        end
        return oor;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
//   clk  : destination clock
//   srst : synchronous active-high reset, forces the output to 1 (idle level)
//   d    : asynchronous input
//   q    : synchronized output
module sync_2ff (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: register-file back end for an SPI slave.
// Decodes a {RD, address} command word followed by data words from the
// slave's receive stream, commits writes to the register array and supplies
// the next word to shift out on miso.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   ss_n       : raw SPI slave select (asynchronous, synchronized here)
//   rx_data    : word received by the slave, valid with rx_strobe
//   rx_strobe  : one-cycle pulse per received word
//   tx_strobe  : one-cycle pulse when the slave samples tx_data (not needed here)
//   tx_data    : registered word for the slave to transmit next
//   reg_q      : flattened register contents, reg k at [k*Nbit +: Nbit]
//   wr_pulse   : one-cycle pulse after each committed write
//   wr_addr    : address of the last committed write
// Build option: define SPI_REG_AUTOINC_EN to advance the address after every
// data word (burst access). Without it only the first data word of a frame
// is acted on.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int              Nbit        = 8,
    parameter int              NREGS       = 16,
    parameter logic [Nbit-1:0] STATUS_BYTE = 8'hA5,
    parameter logic [Nbit-1:0] RESET_VAL   = '0,
    localparam int             AW          = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss_n,
    input  logic [Nbit-1:0]       rx_data,
    input  logic                  rx_strobe,
    input  logic                  tx_strobe,
    output logic [Nbit-1:0]       tx_data,
    output logic [NREGS*Nbit-1:0] reg_q,
    output logic                  wr_pulse,
    output logic [AW-1:0]         wr_addr
);

    logic [Nbit-1:0] regs [NREGS];
    state_t          state;
    logic            ss_s;
    logic            ss_prev_reg;
    logic [1:0]      settle_reg;
    logic            rd_reg;
    logic            oor_reg;
    logic [AW-1:0]   addr_reg;

    // The slave's sample point needs no action: tx_data is already stable.
    logic unused_tx_strobe;
    assign unused_tx_strobe = tx_strobe;

    sync_2ff u_ss_sync (
        .clk  (clk),
        .srst (rst),
        .d    (ss_n),
        .q    (ss_s)
    );

    logic frame_start;
    logic frame_end;
    assign frame_start = ss_prev_reg & ~ss_s;
    assign frame_end   = ~ss_prev_reg & ss_s;

    // Command decode of the incoming word
    logic            rx_rd;
    logic [AW-1:0]   rx_addr;
    logic            rx_oor;
    logic [Nbit-1:0] cmd_word;
    assign rx_rd    = rx_data[Nbit-1];
    assign rx_addr  = rx_data[AW-1:0];
    assign rx_oor   = is_oor(32'(rx_data), Nbit, NREGS);
    assign cmd_word = rx_oor ? '1 : regs[rx_addr];

`ifdef SPI_REG_AUTOINC_EN
    logic [Nbit-1:0] cmd_reg;
    logic [AW-1:0]   next_addr;
    logic [Nbit-1:0] next_cmd;
    logic            next_oor;
    logic [Nbit-1:0] next_word;

    // Re-run the range check on the original command with the advanced
    // address, so illegal upper bits keep the whole burst out of range.
    always_comb begin
        next_addr = (addr_reg >= AW'(NREGS - 1)) ? '0 : addr_reg + AW'(1);
        next_cmd  = cmd_reg;
        next_cmd[AW-1:0] = next_addr;
        next_oor  = is_oor(32'(next_cmd), Nbit, NREGS);
        next_word = next_oor ? '1 : regs[next_addr];
    end
`else
    logic done_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_IDLE;
            ss_prev_reg <= 1'b1;
            settle_reg  <= 2'd0;
            rd_reg      <= 1'b0;
            oor_reg     <= 1'b0;
            addr_reg    <= '0;
            tx_data     <= STATUS_BYTE;
            wr_pulse    <= 1'b0;
            wr_addr     <= '0;
`ifdef SPI_REG_AUTOINC_EN
            cmd_reg     <= '0;
`else
            done_reg    <= 1'b0;
`endif
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            wr_pulse    <= 1'b0;
            ss_prev_reg <= ss_s;
            case (state)
                WAIT_IDLE: begin
                    // The synchronizer comes out of reset reading "idle", so
                    // its output is only trusted after two clocks; otherwise a
                    // frame in progress at reset would look like a new start.
                    tx_data <= STATUS_BYTE;
                    if (settle_reg != 2'd2) begin
                        settle_reg <= settle_reg + 2'd1;
                    end else if (ss_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    tx_data <= STATUS_BYTE;
                    if (frame_start) begin
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (rx_strobe) begin
                        rd_reg   <= rx_rd;
                        addr_reg <= rx_addr;
                        oor_reg  <= rx_oor;
                        tx_data  <= rx_rd ? cmd_word : '0;
                        state    <= DATA;
`ifdef SPI_REG_AUTOINC_EN
                        cmd_reg  <= rx_data;
`else
                        done_reg <= 1'b0;
`endif
                    end
                    if (frame_end) begin
                        state   <= IDLE;
                        tx_data <= STATUS_BYTE;
                    end
                end
                DATA: begin
                    if (rx_strobe) begin
`ifdef SPI_REG_AUTOINC_EN
                        if (!rd_reg && !oor_reg) begin
                            regs[addr_reg] <= rx_data;
                            wr_pulse       <= 1'b1;
                            wr_addr        <= addr_reg;
                        end
                        addr_reg <= next_addr;
                        oor_reg  <= next_oor;
                        tx_data  <= rd_reg ? next_word : '0;
`else
                        if (!done_reg && !rd_reg && !oor_reg) begin
                            regs[addr_reg] <= rx_data;
                            wr_pulse       <= 1'b1;
                            wr_addr        <= addr_reg;
                        end
                        done_reg <= 1'b1;
                        tx_data  <= '0;
`endif
                    end
                    // A strobe in the same cycle has already been handled above
                    if (frame_end) begin
                        state   <= IDLE;
                        tx_data <= STATUS_BYTE;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg_q
            assign reg_q[gi*Nbit +: Nbit] = regs[gi];
        end
    endgenerate

endmodule

// File: tb/tb_spi_reg_bank.sv
// Testbench for spi_reg_bank: word-level frames (strobes driven directly),
// directed table vectors, hand-written abort/reset sequences and random frames
// checked against a register-file model.
module tb_spi_reg_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic         ss_n;
    logic [7:0]   rx_data;
    logic         rx_strobe;
    logic         tx_strobe;
    logic [7:0]   tx_data;
    logic [127:0] reg_q;
    logic         wr_pulse;
    logic [3:0]   wr_addr;

    always #5 clk = ~clk;

    spi_reg_bank dut (
        .clk       (clk),
        .rst       (rst),
        .ss_n      (ss_n),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .tx_strobe (tx_strobe),
        .tx_data   (tx_data),
        .reg_q     (reg_q),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr)
    );

`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    logic [7:0] mregs [16];

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) wr_cnt++;
    end

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = mregs[k];
        return v;
    endfunction

    // Model of one complete frame: what the master receives per word and
    // which registers change, straight from the command semantics.
    task automatic model_frame(input logic [3:0][7:0] w, input int n,
                               output logic [3:0][7:0] exp_rx, output int nwr, output int last);
        logic       rd;
        logic       oor;
        int         a;
        int         ad;
        bit         active;
        rd  = w[0][7];
        a   = int'(w[0][3:0]);
        oor = (w[0][6:4] != 3'd0);
        exp_rx = '0;
        exp_rx[0] = 8'hA5;
        nwr = 0;
        last = -1;
        for (int k = 1; k < n; k++) begin
            active = AUTOINC || (k == 1);
            ad = (a + k - 1) % 16;
            exp_rx[k] = (rd && active) ? (oor ? 8'hFF : mregs[ad]) : 8'h00;
            if (!rd && active && !oor) begin
                mregs[ad] = w[k];
                nwr++;
                last = ad;
            end
        end
    endtask

    // Full frame: per word, slave samples tx_data, then receives the word.
    task automatic run_frame(input logic [3:0][7:0] w, input int n, output logic [3:0][7:0] got);
        got = '0;
        ss_n = 1'b0;
        tick(4);
        for (int k = 0; k < n; k++) begin
            tx_strobe = 1'b1;
            got[k] = tx_data;
            tick(1);
            tx_strobe = 1'b0;
            tick(3);
            rx_data = w[k];
            rx_strobe = 1'b1;
            tick(1);
            rx_strobe = 1'b0;
            tick(2);
        end
        ss_n = 1'b1;
        tick(5);
    endtask

    typedef struct packed {
        logic [3:0][7:0] w;
        logic [3:0][7:0] exp_rx;
        logic [7:0]      n;
        logic [7:0]      exp_wr;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input int n, input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input int nwr);
        vec_t v;
        v.w      = {8'h00, b2, b1, b0};
        v.exp_rx = {8'h00, e2, e1, e0};
        v.n      = 8'(n);
        v.exp_wr = 8'(nwr);
        return v;
    endfunction

    initial begin
        logic [3:0][7:0] got;
        logic [3:0][7:0] exp_rx;
        logic [3:0][7:0] w;
        int              nwr;
        int              last;
        int              wr0;
        int              n;

        vecs[0] = mk(8'h03, 8'h5A, 8'h00, 2, 8'hA5, 8'h00, 8'h00, 1);
        vecs[1] = mk(8'h83, 8'h00, 8'h00, 2, 8'hA5, 8'h5A, 8'h00, 0);
        vecs[2] = mk(8'h20, 8'hFF, 8'h00, 2, 8'hA5, 8'h00, 8'h00, 0);
        vecs[3] = mk(8'hA0, 8'h00, 8'h00, 2, 8'hA5, 8'hFF, 8'h00, 0);
        if (AUTOINC) begin
            vecs[4] = mk(8'h0F, 8'h11, 8'h22, 3, 8'hA5, 8'h00, 8'h00, 2);
            vecs[5] = mk(8'h8F, 8'h00, 8'h00, 3, 8'hA5, 8'h11, 8'h22, 0);
        end else begin
            vecs[4] = mk(8'h0F, 8'h11, 8'h22, 3, 8'hA5, 8'h00, 8'h00, 1);
            vecs[5] = mk(8'h8F, 8'h00, 8'h00, 3, 8'hA5, 8'h11, 8'h00, 0);
        end

        for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
        rst = 1'b1; ss_n = 1'b1; rx_data = '0; rx_strobe = 1'b0; tx_strobe = 1'b0;
        tick(3);
        rst = 1'b0;
        check("reset tx_data", 128'(tx_data), 128'h A5);
        check("reset wr_pulse", 128'(wr_pulse), 128'h0);
        check("reset wr_addr", 128'(wr_addr), 128'h0);
        check("reset reg_q", reg_q, 128'h0);
        tick(6);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            wr0 = wr_cnt;
            model_frame(vecs[i].w, int'(vecs[i].n), exp_rx, nwr, last);
            run_frame(vecs[i].w, int'(vecs[i].n), got);
            $display("vec %0d cmd %h words %0d miso %h", i, vecs[i].w[0], vecs[i].n, got);
            for (int k = 0; k < int'(vecs[i].n); k++)
                check($sformatf("vec%0d miso%0d", i, k), 128'(got[k]), 128'(vecs[i].exp_rx[k]));
            check($sformatf("vec%0d wr_cnt", i), 128'(wr_cnt - wr0), 128'(vecs[i].exp_wr));
            check($sformatf("vec%0d reg_q", i), reg_q, model_flat());
            if (last >= 0) check($sformatf("vec%0d wr_addr", i), 128'(wr_addr), 128'(last));
        end

        // Frame ends mid data word: nothing committed, back to IDLE
        wr0 = wr_cnt;
        ss_n = 1'b0;
        tick(4);
        tx_strobe = 1'b1; tick(1); tx_strobe = 1'b0; tick(3);
        rx_data = 8'h05; rx_strobe = 1'b1; tick(1); rx_strobe = 1'b0; tick(2);
        tx_strobe = 1'b1; tick(1); tx_strobe = 1'b0; tick(4);
        ss_n = 1'b1;
        tick(5);
        $display("abort frame cmd 05 after 4 bits");
        check("abort reg_q", reg_q, model_flat());
        check("abort wr_cnt", 128'(wr_cnt - wr0), 128'h0);
        check("abort tx_data", 128'(tx_data), 128'hA5);
        w = {8'h00, 8'h00, 8'h77, 8'h05};
        model_frame(w, 2, exp_rx, nwr, last);
        run_frame(w, 2, got);
        $display("post-abort frame cmd 05 miso %h", got);
        check("post-abort miso0", 128'(got[0]), 128'hA5);
        check("post-abort reg_q", reg_q, model_flat());
        check("post-abort wr_addr", 128'(wr_addr), 128'h5);

        // Reset after the command word: rest of frame ignored
        wr0 = wr_cnt;
        ss_n = 1'b0;
        tick(4);
        rx_data = 8'h07; rx_strobe = 1'b1; tick(1); rx_strobe = 1'b0; tick(2);
        rst = 1'b1; tick(1); rst = 1'b0;
        for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
        check("midrst reg_q", reg_q, 128'h0);
        check("midrst tx_data", 128'(tx_data), 128'hA5);
        tick(3);
        rx_data = 8'h99; rx_strobe = 1'b1; tick(1); rx_strobe = 1'b0; tick(3);
        ss_n = 1'b1;
        tick(6);
        $display("reset mid-frame cmd 07, trailing data 99");
        check("midrst ignored reg_q", reg_q, 128'h0);
        check("midrst wr_cnt", 128'(wr_cnt - wr0), 128'h0);
        w = {8'h00, 8'h00, 8'h99, 8'h07};
        model_frame(w, 2, exp_rx, nwr, last);
        run_frame(w, 2, got);
        $display("post-reset frame cmd 07 miso %h", got);
        check("post-reset reg_q", reg_q, model_flat());
        check("post-reset wr_addr", 128'(wr_addr), 128'h7);

        // Random frames against the model
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(1, 4);
            w[0] = {1'($urandom % 2), 3'(($urandom % 5 == 0) ? $urandom_range(1, 7) : 0), 4'($urandom % 16)};
            for (int k = 1; k < 4; k++) w[k] = 8'($urandom);
            wr0 = wr_cnt;
            model_frame(w, n, exp_rx, nwr, last);
            run_frame(w, n, got);
            $display("rand %0d cmd %h words %0d miso %h", i, w[0], n, got);
            for (int k = 0; k < n; k++)
                check($sformatf("rand%0d miso%0d", i, k), 128'(got[k]), 128'(exp_rx[k]));
            check($sformatf("rand%0d wr_cnt", i), 128'(wr_cnt - wr0), 128'(nwr));
            check($sformatf("rand%0d reg_q", i), reg_q, model_flat());
            if (last >= 0) check($sformatf("rand%0d wr_addr", i), 128'(wr_addr), 128'(last));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
